// File: rtl/pkt_demux_pkg.sv
// -----------------------------------------------------------------------------
// pkt_demux_pkg
// Shared definitions for the packet demultiplexer:
//   state_t            - steering FSM encoding (IDLE=0, FWD=1, DROP=2)
//   DROP_CNT_WIDTH     - width of the saturating dropped-packet counter
//   DEFAULT_DST_LSB    - default LSB of the one-hot destination field in tuser
//   DEFAULT_NUM_QUEUES - default number of output ports
// -----------------------------------------------------------------------------
package pkt_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam int DROP_CNT_WIDTH     = 32;
    localparam int DEFAULT_DST_LSB    = 24;
    localparam int DEFAULT_NUM_QUEUES = 4;

endpackage

// File: rtl/pkt_demux_axis_out_stage.sv
// -----------------------------------------------------------------------------
// axis_out_stage
// One-beat registered AXI-Stream master stage. A beat presented on in_* is
// captured when load is high; the stage reports free when it is empty or its
// current beat is being taken this cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (valid only)
//   load                capture in_* this cycle (caller guarantees free)
//   in_tdata/tkeep/tuser/tlast   beat to capture
//   free                stage can accept a beat this cycle
//   m_axis_*            registered AXI-Stream master outputs
//   m_axis_tready       downstream accept
// -----------------------------------------------------------------------------
module axis_out_stage
    import pkt_demux_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int KEEP_W = 32,
    parameter int USER_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] in_tdata,
    input  logic [KEEP_W-1:0] in_tkeep,
    input  logic [USER_W-1:0] in_tuser,
    input  logic              in_tlast,
    output logic              free,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic [USER_W-1:0] m_axis_tuser,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
);

    logic              tvalid_d, tvalid_q;
    logic [DATA_W-1:0] tdata_d,  tdata_q;
    logic [KEEP_W-1:0] tkeep_d,  tkeep_q;
    logic [USER_W-1:0] tuser_d,  tuser_q;
    logic              tlast_d,  tlast_q;

    assign free = ~tvalid_q | m_axis_tready;

    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = in_tdata;
            tkeep_d  = in_tkeep;
            tuser_d  = in_tuser;
            tlast_d  = in_tlast;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // Stage boundary: only the valid flag is reset; the payload is qualified by it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid_q <= 1'b0;
        end else begin
            tvalid_q <= tvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        tdata_q <= tdata_d;
        tkeep_q <= tkeep_d;
        tuser_q <= tuser_d;
        tlast_q <= tlast_d;
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: rtl/pkt_demux.sv
// -----------------------------------------------------------------------------
// pkt_demux
// Steers whole AXI-Stream packets from one slave port to one of four master
// ports, chosen by a one-hot destination field tuser[C_DST_LSB +: 4] on the
// first beat. Packets whose destination field is empty are consumed and
// counted in drop_count (saturating). Each output has a one-beat register.
//
// Build option: define PKT_DEMUX_MULTICAST_EN to deliver each beat to every
// destination bit set (all selected stages must be free at once). Without it
// only the lowest set destination bit is used.
//
// Ports:
//   axis_clk, aresetn            clock, asynchronous active-low reset
//   s_axis_*                     slave input stream (tready is combinational
//                                from the output stages, never from tvalid)
//   m_axis_*_k (k=0..3)          registered master output streams
//   drop_count                   number of dropped packets, saturating
// -----------------------------------------------------------------------------
module pkt_demux
    import pkt_demux_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_QUEUES       = DEFAULT_NUM_QUEUES,
    parameter int C_NUM_QUEUES_WIDTH = 2,
    parameter int C_DST_LSB          = DEFAULT_DST_LSB
) (
    input  logic                            axis_clk,
    input  logic                            aresetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_0,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_0,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_0,
    output logic                            m_axis_tvalid_0,
    output logic                            m_axis_tlast_0,
    input  logic                            m_axis_tready_0,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_1,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_1,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_1,
    output logic                            m_axis_tvalid_1,
    output logic                            m_axis_tlast_1,
    input  logic                            m_axis_tready_1,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_2,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_2,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_2,
    output logic                            m_axis_tvalid_2,
    output logic                            m_axis_tlast_2,
    input  logic                            m_axis_tready_2,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_3,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_3,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_3,
    output logic                            m_axis_tvalid_3,
    output logic                            m_axis_tlast_3,
    input  logic                            m_axis_tready_3,

    output logic [DROP_CNT_WIDTH-1:0]       drop_count
);

    localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;

    state_t                      state_d, state_q;
    logic [C_NUM_QUEUES-1:0]     cur_dst_d, cur_dst_q;
    logic [DROP_CNT_WIDTH-1:0]   drop_count_d, drop_count_q;

    logic [C_NUM_QUEUES-1:0]     dst, sel, target, free, load;
    logic [C_NUM_QUEUES-1:0]     m_tready, m_tvalid, m_tlast;
    logic [C_AXIS_DATA_WIDTH-1:0]  m_tdata [C_NUM_QUEUES];
    logic [KEEP_W-1:0]             m_tkeep [C_NUM_QUEUES];
    logic [C_AXIS_TUSER_WIDTH-1:0] m_tuser [C_NUM_QUEUES];
    logic                        drop_path, ready_int, accept;

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic [C_NUM_QUEUES_WIDTH-1:0] lowest_idx(input logic [C_NUM_QUEUES-1:0] v);
        logic [C_NUM_QUEUES_WIDTH-1:0] idx;
        idx = '0;
        for (int i = C_NUM_QUEUES - 1; i >= 0; i--) begin
            if (v[i]) idx = C_NUM_QUEUES_WIDTH'(i);
        end
        return idx;
    endfunction

    assign dst = s_axis_tuser[C_DST_LSB +: C_NUM_QUEUES];

`ifdef PKT_DEMUX_MULTICAST_EN
    assign sel = dst;
`else
    assign sel = (dst == '0) ? '0 : (C_NUM_QUEUES'(1) << lowest_idx(dst));
`endif

    assign m_tready = {m_axis_tready_3, m_axis_tready_2, m_axis_tready_1, m_axis_tready_0};

    // Dropping needs no output stage, so it is always ready. Forwarding
    // requires every targeted stage to be free (one stage unless multicast).
    always_comb begin
        drop_path = (state_q == ST_DROP) || ((state_q == ST_IDLE) && (dst == '0));
        target    = (state_q == ST_FWD) ? cur_dst_q : sel;
        ready_int = drop_path | (&(free | ~target));
    end

    // Held low while reset is asserted so nothing is accepted during reset.
    assign s_axis_tready = aresetn & ready_int;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign load          = (accept && !drop_path) ? target : '0;

    always_comb begin
        state_d      = state_q;
        cur_dst_d    = cur_dst_q;
        drop_count_d = drop_count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (dst == '0) begin
                        drop_count_d = sat_inc(drop_count_q);
                        if (!s_axis_tlast) state_d = ST_DROP;
                    end else begin
                        cur_dst_d = sel;
                        if (!s_axis_tlast) state_d = ST_FWD;
                    end
                end
            end
            ST_FWD, ST_DROP: begin
                if (accept && s_axis_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage boundary: steering FSM and drop counter.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            cur_dst_q    <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_dst_q    <= cur_dst_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;

    for (genvar k = 0; k < C_NUM_QUEUES; k++) begin : g_stage
        axis_out_stage #(
            .DATA_W (C_AXIS_DATA_WIDTH),
            .KEEP_W (KEEP_W),
            .USER_W (C_AXIS_TUSER_WIDTH)
        ) u_stage (
            .clk           (axis_clk),
            .rst_n         (aresetn),
            .load          (load[k]),
            .in_tdata      (s_axis_tdata),
            .in_tkeep      (s_axis_tkeep),
            .in_tuser      (s_axis_tuser),
            .in_tlast      (s_axis_tlast),
            .free          (free[k]),
            .m_axis_tdata  (m_tdata[k]),
            .m_axis_tkeep  (m_tkeep[k]),
            .m_axis_tuser  (m_tuser[k]),
            .m_axis_tvalid (m_tvalid[k]),
            .m_axis_tlast  (m_tlast[k]),
            .m_axis_tready (m_tready[k])
        );
    end

    assign m_axis_tdata_0  = m_tdata[0];
    assign m_axis_tkeep_0  = m_tkeep[0];
    assign m_axis_tuser_0  = m_tuser[0];
    assign m_axis_tvalid_0 = m_tvalid[0];
    assign m_axis_tlast_0  = m_tlast[0];

    assign m_axis_tdata_1  = m_tdata[1];
    assign m_axis_tkeep_1  = m_tkeep[1];
    assign m_axis_tuser_1  = m_tuser[1];
    assign m_axis_tvalid_1 = m_tvalid[1];
    assign m_axis_tlast_1  = m_tlast[1];

    assign m_axis_tdata_2  = m_tdata[2];
    assign m_axis_tkeep_2  = m_tkeep[2];
    assign m_axis_tuser_2  = m_tuser[2];
    assign m_axis_tvalid_2 = m_tvalid[2];
    assign m_axis_tlast_2  = m_tlast[2];

    assign m_axis_tdata_3  = m_tdata[3];
    assign m_axis_tkeep_3  = m_tkeep[3];
    assign m_axis_tuser_3  = m_tuser[3];
    assign m_axis_tvalid_3 = m_tvalid[3];
    assign m_axis_tlast_3  = m_tlast[3];

endmodule

// File: tb/tb_pkt_demux.sv
// -----------------------------------------------------------------------------
// tb_pkt_demux
// Scoreboard bench for pkt_demux: the driver pushes the expected beat for each
// destination port on accept; a monitor pops and compares on every output
// handshake. Directed checks cover reset, latency, backpressure, drop and
// the multicast option (PKT_DEMUX_MULTICAST_EN).
// -----------------------------------------------------------------------------
module tb_pkt_demux;

    localparam int DW = 256;
    localparam int KW = DW / 8;
    localparam int UW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [UW-1:0] s_tuser;
    logic          s_tvalid, s_tlast, s_tready;

    logic [DW-1:0] m_tdata_0, m_tdata_1, m_tdata_2, m_tdata_3;
    logic [KW-1:0] m_tkeep_0, m_tkeep_1, m_tkeep_2, m_tkeep_3;
    logic [UW-1:0] m_tuser_0, m_tuser_1, m_tuser_2, m_tuser_3;
    logic          m_tvalid_0, m_tvalid_1, m_tvalid_2, m_tvalid_3;
    logic          m_tlast_0, m_tlast_1, m_tlast_2, m_tlast_3;
    logic          m_tready_0, m_tready_1, m_tready_2, m_tready_3;
    logic [31:0]   drop_count;

    logic [DW-1:0] md [4];
    logic [UW-1:0] mu [4];
    logic [3:0]    mv, ml, mr;

    assign md[0] = m_tdata_0;  assign md[1] = m_tdata_1;
    assign md[2] = m_tdata_2;  assign md[3] = m_tdata_3;
    assign mu[0] = m_tuser_0;  assign mu[1] = m_tuser_1;
    assign mu[2] = m_tuser_2;  assign mu[3] = m_tuser_3;
    assign mv = {m_tvalid_3, m_tvalid_2, m_tvalid_1, m_tvalid_0};
    assign ml = {m_tlast_3, m_tlast_2, m_tlast_1, m_tlast_0};
    assign mr = {m_tready_3, m_tready_2, m_tready_1, m_tready_0};

    always #5 clk = ~clk;

    pkt_demux dut (
        .axis_clk        (clk),
        .aresetn         (rst_n),
        .s_axis_tdata    (s_tdata),
        .s_axis_tkeep    (s_tkeep),
        .s_axis_tuser    (s_tuser),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tlast    (s_tlast),
        .s_axis_tready   (s_tready),
        .m_axis_tdata_0  (m_tdata_0), .m_axis_tkeep_0 (m_tkeep_0), .m_axis_tuser_0 (m_tuser_0),
        .m_axis_tvalid_0 (m_tvalid_0), .m_axis_tlast_0 (m_tlast_0), .m_axis_tready_0 (m_tready_0),
        .m_axis_tdata_1  (m_tdata_1), .m_axis_tkeep_1 (m_tkeep_1), .m_axis_tuser_1 (m_tuser_1),
        .m_axis_tvalid_1 (m_tvalid_1), .m_axis_tlast_1 (m_tlast_1), .m_axis_tready_1 (m_tready_1),
        .m_axis_tdata_2  (m_tdata_2), .m_axis_tkeep_2 (m_tkeep_2), .m_axis_tuser_2 (m_tuser_2),
        .m_axis_tvalid_2 (m_tvalid_2), .m_axis_tlast_2 (m_tlast_2), .m_axis_tready_2 (m_tready_2),
        .m_axis_tdata_3  (m_tdata_3), .m_axis_tkeep_3 (m_tkeep_3), .m_axis_tuser_3 (m_tuser_3),
        .m_axis_tvalid_3 (m_tvalid_3), .m_axis_tlast_3 (m_tlast_3), .m_axis_tready_3 (m_tready_3),
        .drop_count      (drop_count)
    );

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [UW-1:0] mk_user(input logic [3:0] dst, input logic [7:0] tag);
        logic [UW-1:0] u;
        u = {16{tag}};
        u[24 +: 4] = dst;
        return u;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one beat (called just after a rising edge); returns the number of
    // cycles spent waiting for s_axis_tready. exp_mask lists the ports that
    // should receive this beat.
    task automatic send_beat(input logic [31:0] tag, input logic [3:0] dst, input logic last,
                             input logic [3:0] exp_mask, output int waits);
        exp_t e;
        waits    = 0;
        s_tdata  = {8{tag}};
        s_tkeep  = '1;
        s_tuser  = mk_user(dst, tag[7:0]);
        s_tlast  = last;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_tready) begin
                for (int k = 0; k < 4; k++) begin
                    if (exp_mask[k]) begin
                        e.port = k;
                        e.data = s_tdata;
                        e.user = s_tuser;
                        e.last = last;
                        sb.push_back(e);
                    end
                end
                @(posedge clk);
                #1;
                s_tvalid = 1'b0;
                break;
            end
            waits++;
            if (waits > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: tag %0h not accepted after %0d cycles", tag, waits);
                @(posedge clk);
                #1;
                s_tvalid = 1'b0;
                break;
            end
        end
    endtask

    // Monitor: every output handshake must match the oldest expected beat of that port.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst_n && mv[k] && mr[k]) begin
                int idx;
                idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (sb[i].port == k) begin
                        idx = i;
                        break;
                    end
                end
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: port %0d got data %0h, expected none", k, md[k][31:0]);
                end else begin
                    if (md[k] !== sb[idx].data || mu[k] !== sb[idx].user || ml[k] !== sb[idx].last) begin
                        errors++;
                        $display("FAIL beat_port%0d: got data %0h last %0b, expected data %0h last %0b",
                                 k, md[k][31:0], ml[k], sb[idx].data[31:0], sb[idx].last);
                    end
                    sb.delete(idx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, wsum;
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        {m_tready_3, m_tready_2, m_tready_1, m_tready_0} = 4'b1111;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tvalid", 64'(mv), 64'h0);
        chk("reset_tready", 64'(s_tready), 64'h0);
        chk("reset_drop_count", 64'(drop_count), 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3-beat packet to port 2, all outputs ready
        send_beat(32'hA1, 4'b0100, 1'b0, 4'b0100, w);
        chk("t1_first_wait", 64'(w), 64'h0);
        chk("t1_latency_valid", 64'(mv), 64'h4);
        chk("t1_first_data", 64'(md[2][31:0]), 64'hA1);
        send_beat(32'hA2, 4'b0001, 1'b0, 4'b0100, w);
        send_beat(32'hA3, 4'b0000, 1'b1, 4'b0100, w);
        chk("t1_last_on_third", 64'(ml[2]), 64'h1);
        chk("t1_other_ports_idle", 64'(mv & 4'b1011), 64'h0);
        repeat (3) @(posedge clk);
        #1;

        // Port 1 stalled mid-packet
        m_tready_1 = 1'b0;
        fork
            begin
                send_beat(32'hB1, 4'b0010, 1'b0, 4'b0010, w);
                send_beat(32'hB2, 4'b0010, 1'b0, 4'b0010, w);
                chk("t2_stall_waits_ge3", 64'(w >= 3), 64'h1);
                send_beat(32'hB3, 4'b0010, 1'b0, 4'b0010, w);
                send_beat(32'hB4, 4'b0010, 1'b1, 4'b0010, w);
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                chk("t2_tready_low_when_full", 64'(s_tready), 64'h0);
                repeat (2) @(posedge clk);
                #1;
                m_tready_1 = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Dropped 2-beat packet, then a 1-beat packet to port 0
        send_beat(32'hC1, 4'b0000, 1'b0, 4'b0000, w);
        chk("t3_drop_count_first", 64'(drop_count), 64'h1);
        send_beat(32'hC2, 4'b0100, 1'b1, 4'b0000, w);
        chk("t3_drop_count_after", 64'(drop_count), 64'h1);
        send_beat(32'hD1, 4'b0001, 1'b1, 4'b0001, w);
        chk("t3_deliver_port0", 64'(mv), 64'h1);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back single-beat packets to ports 0, 3, 0
        wsum = 0;
        send_beat(32'hE0, 4'b0001, 1'b1, 4'b0001, w); wsum += w;
        send_beat(32'hE3, 4'b1000, 1'b1, 4'b1000, w); wsum += w;
        send_beat(32'hE4, 4'b0001, 1'b1, 4'b0001, w); wsum += w;
        chk("t4_one_accept_per_cycle", 64'(wsum), 64'h0);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-packet in FWD
        send_beat(32'hF1, 4'b0100, 1'b0, 4'b0100, w);
        send_beat(32'hF2, 4'b0100, 1'b0, 4'b0100, w);
        rst_n = 1'b0;
        #1;
        chk("t5_reset_tvalid", 64'(mv), 64'h0);
        chk("t5_reset_drop_count", 64'(drop_count), 64'h0);
        chk("t5_reset_tready", 64'(s_tready), 64'h0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(32'hF3, 4'b0001, 1'b1, 4'b0001, w);
        chk("t5_first_beat_after_reset", 64'(mv), 64'h1);
        repeat (3) @(posedge clk);
        #1;

        // dst=1010 while port 3 holds an un-taken beat
        m_tready_3 = 1'b0;
        send_beat(32'h61, 4'b1000, 1'b1, 4'b1000, w);
        fork
            begin
`ifdef PKT_DEMUX_MULTICAST_EN
                send_beat(32'h62, 4'b1010, 1'b1, 4'b1010, w);
                chk("t6_mc_wait_ge3", 64'(w >= 3), 64'h1);
                chk("t6_mc_same_cycle", 64'(mv & 4'b1010), 64'hA);
`else
                send_beat(32'h62, 4'b1010, 1'b1, 4'b0010, w);
                chk("t6_uc_no_wait", 64'(w), 64'h0);
                chk("t6_uc_port1", 64'(mv[1]), 64'h1);
`endif
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                m_tready_3 = 1'b1;
            end
        join

        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_demux.md
Name: pkt_demux

Overview:
- Single AXI-Stream slave feeding C_NUM_QUEUES AXI-Stream masters; it is the fan-out counterpart of the per-port round-robin output arbitration.
- Steers whole packets to an output port selected by a one-hot destination field in tuser on the first beat.
- Packets with an empty destination field are dropped and counted.
- Each output has a one-beat registered stage.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width
- C_AXIS_TUSER_WIDTH, 128, tuser width
- C_NUM_QUEUES, 4, number of output ports (fixed 4 by port list)
- C_NUM_QUEUES_WIDTH, 2, log2(C_NUM_QUEUES)
- C_DST_LSB, 24, LSB of one-hot destination field tuser[C_DST_LSB +: C_NUM_QUEUES]

Ports:
- axis_clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata/tkeep/tuser  in  DW/DW/8/UW  input beat
- s_axis_tvalid, s_axis_tlast  in  1  input handshake
- s_axis_tready  out  1  input accept
- m_axis_tdata_k/tkeep_k/tuser_k (k=0..3)  out  DW/DW/8/UW  output beat, registered
- m_axis_tvalid_k, m_axis_tlast_k (k=0..3)  out  1  output handshake, registered
- m_axis_tready_k (k=0..3)  in  1  downstream accept
- drop_count  out  32  number of dropped packets, saturating

Behaviour:
- Reset, asynchronous on aresetn low:
  - state=IDLE, cur_dst=0, all m_axis_tvalid_k=0, drop_count=0, s_axis_tready=0.
  - Data registers are don't-care.
  - Reset mid-packet discards the stage contents. The remainder of the interrupted packet is treated as a new packet from its next beat.
- Output stage k:
  - free_k = ~m_axis_tvalid_k | m_axis_tready_k.
  - On load, capture the beat and set m_axis_tvalid_k=1.
  - Otherwise, clear m_axis_tvalid_k when m_axis_tready_k=1.
  - Latency from input accept to output valid is 1 cycle.
  - Full throughput of 1 beat/cycle when downstream is always ready.
- Target selection: dst = s_axis_tuser[C_DST_LSB +: C_NUM_QUEUES] sampled on the first beat only; sel = lowest set bit of dst (one-hot).
- States:
  - IDLE, waiting for the first beat:
    - dst==0: s_axis_tready=1. On accept, drop_count += 1 (saturates at 0xFFFFFFFF). Go DROP if !tlast, else stay IDLE.
    - dst!=0: s_axis_tready = free of sel. On accept, load stage sel and latch cur_dst=sel. Go FWD if !tlast, else stay IDLE.
  - FWD:
    - s_axis_tready = free of cur_dst; beats load stage cur_dst.
    - Accept with tlast -> IDLE.
    - Later-beat tuser is ignored for steering but forwarded.
  - DROP:
    - s_axis_tready=1, beats discarded.
    - Accept with tlast -> IDLE.
- Single-beat packets (first beat has tlast) complete in IDLE with no state change.
- No output is ever loaded while it holds an un-taken beat.
- Non-target outputs are unaffected and keep draining during a packet.
- Packets on one output never interleave; packet order per output equals input order.
- s_axis_tready is combinational from m_axis_tready_k, with no combinational path from s_axis_tvalid.

Optional Feature:
- PKT_DEMUX_MULTICAST_EN defined:
  - sel = dst, all set bits.
  - A beat is accepted only when every selected stage is free, and loads all of them in the same cycle.
  - cur_dst holds the multi-hot mask.
- Not defined: lowest set bit only; extra destination bits are ignored.
- Dropping of dst==0 packets is identical in both builds.

Decomposition:
- Package pkt_demux_pkg: state encodings IDLE=0, FWD=1, DROP=2 (2-bit); DROP_CNT_WIDTH=32; default C_DST_LSB.
- Sub-module axis_out_stage: one-beat registered stage with load, free, and AXIS master outputs. Instantiated C_NUM_QUEUES times in a generate loop.
- The top level holds the FSM, destination decode and drop counter.

Test Plan:
- 3-beat packet, dst=4'b0100, all tready=1 -> beats appear on port 2 cycles 1..3 after accept, tlast on 3rd; ports 0,1,3 tvalid stay 0.
- Port 1 tready=0 for 5 cycles mid-packet, dst=4'b0010 -> s_axis_tready low while stage 1 is full; no beat lost or duplicated; beat order preserved.
- 2-beat packet dst=0, then 1-beat packet dst=4'b0001 -> drop_count 0->1, no output on any port for the first packet; second packet delivered on port 0.
- Back-to-back 1-beat packets to ports 0,3,0 with all ready -> one accept per cycle, port 0 receives 2 beats in order.
- aresetn pulsed low mid-packet in FWD -> all m_axis_tvalid_k=0 immediately, drop_count=0, state IDLE; the next beat is decoded as a first beat.
- PKT_DEMUX_MULTICAST_EN, dst=4'b1010, port 3 tready=0 -> no accept until both stages 1 and 3 are free, then identical beats on ports 1 and 3 in the same cycle. Without the macro the same stimulus delivers to port 1 only.
